vs1003_sci_reader: RTL

SCI register reader for the VS1003 MP3 decoder: issues an SCI read frame (opcode 0x03, 8-bit address) and shifts the 16-bit register value back in on SO. It is the read-side counterpart of the existing SDI/SCI write path. It shares the XCS/SCK/SI pins with that writer at the top level, where XCS is ANDed and SCK/SI are ORed. It lets game logic poll SCI_HDAT0/1, SCI_DECODE_TIME and SCI_STATUS.

---
 rtl/vs1003_sci_reader.sv | 91 +++++++++
 1 files changed

// File: rtl/vs1003_sci_reader.sv
// vs1003_sci_reader: SCI read frame (opcode 0x03, addr) to the VS1003, returning the 16-bit register value from SO
module vs1003_sci_reader #(
  parameter int SCK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic        SO,
  input  logic        DREQ,
  output logic        XCS,
  output logic        SCK,
  output logic        SI,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, WAIT, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam logic [7:0] HM = 8'(SCK_HALF - 1);
  state_t      state;
  logic [7:0]  cnt;
  logic [4:0]  bitn;
  logic [30:0] sr;
  logic [15:0] rx;
  logic        last;
  assign last = cnt == HM;
  // sr holds frame bits 30..0; frame bit 31 (opcode MSB) is always 0 so SI idles correctly through SETUP
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      XCS   <= 1'b1;
      SCK   <= 1'b0;
      SI    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rdata <= '0;
      cnt   <= '0;
      bitn  <= '0;
      sr    <= '0;
      rx    <= '0;
    end else begin
      done <= 1'b0;
      cnt  <= last ? 8'd0 : cnt + 8'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            sr    <= {7'h03, addr, 16'h0000};
            busy  <= 1'b1;
            XCS   <= !DREQ;
            state <= DREQ ? SETUP : WAIT;
          end
        end
        WAIT: begin
          cnt <= '0;
          if (DREQ) begin
            XCS   <= 1'b0;
            state <= SETUP;
          end
        end
        SETUP: if (last) begin
          SCK   <= 1'b1;
          bitn  <= '0;
          state <= SHIFT;
        end
        SHIFT: if (last) begin
          SCK <= !SCK;
          if (SCK) begin
            if (bitn[4]) rx <= {rx[14:0], SO};
            SI <= sr[30];
            sr <= {sr[29:0], 1'b0};
          end else if (bitn == 5'd31) begin
            SCK   <= 1'b0;
            state <= HOLD;
          end else bitn <= bitn + 5'd1;
        end
        HOLD: if (last) begin
          XCS   <= 1'b1;
          done  <= 1'b1;
          rdata <= rx;
          state <= GAP;
        end
        GAP: if (last) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
